// File: rtl/vpu_fp_exp_collector.sv
// Collects BF16 exp-unit results into an element FIFO and packs LANES of them per
// output word for the DST port, with credit (free slot) reporting and flush support.

module vpu_fp_exp_lane #(
    parameter int OPERAND_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     clr,
    input  logic [OPERAND_WIDTH-1:0] d,
    output logic [OPERAND_WIDTH-1:0] q
);
    // A write wins over a clear so a retiring word can load lane 0 of the next one.
    always_ff @(posedge clk) begin
        if (rst)      q <= '0;
        else if (wr)  q <= d;
        else if (clr) q <= '0;
    end
endmodule

module vpu_fp_exp_collector #(
    parameter int OPERAND_WIDTH = 16,
    parameter int LANES         = 4,
    parameter int DEPTH         = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             exp_done_i,
    input  logic [OPERAND_WIDTH-1:0]         exp_data_i,
    input  logic                             flush_i,
    output logic                             dst_valid_o,
    input  logic                             dst_ready_i,
    output logic [LANES*OPERAND_WIDTH-1:0]   dst_data_o,
    output logic [LANES-1:0]                 dst_mask_o,
    output logic [$clog2(DEPTH+1)-1:0]       free_o,
    output logic                             flush_done_o,
    output logic                             overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int LW = $clog2(LANES);

    typedef enum logic {FILL, HOLD} state_t;

    logic [OPERAND_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count, count_n;
    logic                     empty, full, push, pop;

    state_t                   state_q, state_n;
    logic [LW-1:0]            lane_cnt, lane_cnt_n, lane_sel;
    logic [LANES-1:0]         mask_q, mask_n;
    logic                     flush_pending, flush_pending_n;
    logic                     flush_word, flush_word_n;
    logic                     flush_done_q, flush_done_n;
    logic                     retire;
    logic [LANES-1:0][OPERAND_WIDTH-1:0] lane_q;

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign dst_valid_o = (state_q == HOLD);
    assign pop         = !empty && (!dst_valid_o || dst_ready_i);
    assign push        = exp_done_i && (!full || pop);
    assign retire      = dst_valid_o && dst_ready_i;
    assign count_n     = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= exp_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            free_o     <= CW'(DEPTH);
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count  <= count_n;
            free_o <= CW'(DEPTH) - count_n;
            if (exp_done_i && !push) overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            lane_cnt      <= '0;
            mask_q        <= '0;
            flush_pending <= 1'b0;
            flush_word    <= 1'b0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_n;
            lane_cnt      <= lane_cnt_n;
            mask_q        <= mask_n;
            flush_pending <= flush_pending_n;
            flush_word    <= flush_word_n;
            flush_done_q  <= flush_done_n;
        end
    end

    always_comb begin
        state_n         = state_q;
        lane_cnt_n      = lane_cnt;
        mask_n          = mask_q;
        flush_pending_n = flush_pending | flush_i;
        flush_word_n    = flush_word;
        flush_done_n    = 1'b0;
        if (pop) begin
            if (state_q == HOLD) begin
                // retiring word; the popped element starts the next one in lane 0
                state_n      = FILL;
                lane_cnt_n   = LW'(1);
                mask_n       = '0;
                flush_word_n = 1'b0;
            end else if (lane_cnt == LW'(LANES-1)) begin
                state_n    = HOLD;
                lane_cnt_n = '0;
                mask_n     = '1;
            end else begin
                lane_cnt_n = lane_cnt + LW'(1);
            end
        end else if (state_q == HOLD) begin
            if (dst_ready_i) begin
                state_n      = FILL;
                mask_n       = '0;
                flush_word_n = 1'b0;
            end
        end else if (flush_pending_n && empty) begin
            // flush point: FIFO drained and no word outstanding
            flush_pending_n = 1'b0;
            if (lane_cnt != '0) begin
                state_n      = HOLD;
                mask_n       = (LANES'(1) << lane_cnt) - LANES'(1);
                lane_cnt_n   = '0;
                flush_word_n = 1'b1;
            end else begin
                flush_done_n = 1'b1;
            end
        end
    end

    assign lane_sel = (state_q == HOLD) ? '0 : lane_cnt;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        vpu_fp_exp_lane #(.OPERAND_WIDTH(OPERAND_WIDTH)) u_lane (
            .clk (clk),
            .rst (rst),
            .wr  (pop && (lane_sel == LW'(k))),
            .clr (retire),
            .d   (mem[rd_ptr]),
            .q   (lane_q[k])
        );
    end

    assign dst_data_o   = lane_q;
    assign dst_mask_o   = mask_q;
    assign flush_done_o = flush_done_q | (retire && flush_word);

endmodule

// File: tb/tb_vpu_fp_exp_collector.sv
// Directed and randomized checks of vpu_fp_exp_collector against a word-level model:
// accepted elements are grouped LANES at a time, a flush closes any partial group.

module tb_vpu_fp_exp_collector;
    localparam int OW = 16, LANES = 4, DEPTH = 16, CW = 5;

    logic                  clk = 1'b0, rst = 1'b1;
    logic                  exp_done = 1'b0, flush = 1'b0, dst_ready = 1'b1;
    logic [OW-1:0]         exp_data = '0;
    logic                  dst_valid, flush_done, overflow;
    logic [LANES*OW-1:0]   dst_data;
    logic [LANES-1:0]      dst_mask;
    logic [CW-1:0]         free;

    vpu_fp_exp_collector #(.OPERAND_WIDTH(OW), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .exp_done_i(exp_done), .exp_data_i(exp_data),
        .flush_i(flush), .dst_valid_o(dst_valid), .dst_ready_i(dst_ready),
        .dst_data_o(dst_data), .dst_mask_o(dst_mask), .free_o(free),
        .flush_done_o(flush_done), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [LANES*OW-1:0] data; logic [LANES-1:0] mask; logic fd; } word_t;
    word_t         got[$], expw[$];
    logic [OW-1:0] pend[$];
    int            acc_cyc[$];
    int            cyc = 0, valid_cycles = 0, flush_pulses = 0, exp_pulses = 0;
    int            tests = 0, fails = 0;

    always @(negedge clk) begin
        word_t w;
        cyc++;
        if (dst_valid === 1'b1) valid_cycles++;
        if (flush_done === 1'b1) flush_pulses++;
        if (dst_valid === 1'b1 && dst_ready) begin
            w.data = dst_data; w.mask = dst_mask; w.fd = flush_done;
            got.push_back(w);
            acc_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exv);
        tests++;
        assert (obs === exv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exv);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic make_word(input logic fd);
        word_t w;
        w.data = '0;
        foreach (pend[i]) w.data[i*OW +: OW] = pend[i];
        w.mask = LANES'((1 << pend.size()) - 1);
        w.fd   = fd;
        expw.push_back(w);
        pend.delete();
    endtask

    task automatic model_add(input logic [OW-1:0] d);
        pend.push_back(d);
        if (pend.size() == LANES) make_word(1'b0);
    endtask

    task automatic model_flush();
        if (pend.size() > 0) make_word(1'b1);
        exp_pulses++;
    endtask

    task automatic push(input logic [OW-1:0] d, input bit keep);
        exp_done = 1'b1; exp_data = d;
        tick();
        exp_done = 1'b0;
        if (keep) model_add(d);
    endtask

    task automatic do_flush();
        flush = 1'b1; tick(); flush = 1'b0;
        model_flush();
    endtask

    task automatic drain(input bit rnd);
        for (int i = 0; i < 400; i++) begin
            dst_ready = rnd ? ($urandom % 3 != 0) : 1'b1;
            tick();
            if (free == CW'(DEPTH) && !dst_valid && got.size() >= expw.size()) break;
        end
        dst_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic compare_words(input string tag);
        chk({tag, "_nwords"}, got.size(), expw.size());
        for (int i = 0; i < got.size() && i < expw.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got[i].data, expw[i].data);
            chk($sformatf("%s_mask%0d", tag, i), got[i].mask, expw[i].mask);
            chk($sformatf("%s_fd%0d", tag, i), got[i].fd, expw[i].fd);
        end
        chk({tag, "_flush_pulses"}, flush_pulses, exp_pulses);
        got.delete(); expw.delete(); acc_cyc.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, dst_valid, 1'b0);
        chk({tag, "_data"}, dst_data, '0);
        chk({tag, "_mask"}, dst_mask, '0);
        chk({tag, "_free"}, free, DEPTH);
        chk({tag, "_fdone"}, flush_done, 1'b0);
        chk({tag, "_ovf"}, overflow, 1'b0);
    endtask

    initial begin
        logic [LANES*OW-1:0] held;
        int n, pushed;
        // reset
        repeat (2) tick();
        chk_reset("rst");
        rst = 1'b0;

        // full word, single valid cycle
        valid_cycles = 0;
        push(16'h3F80, 1); push(16'h402E, 1); push(16'h40EC, 1); push(16'h41A0, 1);
        drain(0);
        chk("t1_valid_cycles", valid_cycles, 1);
        chk("t1_word", got.size() > 0 ? got[0].data : '0, 64'h41A0_40EC_402E_3F80);
        compare_words("t1");
        chk("t1_free", free, DEPTH);

        // two words from streaming pushes; one pop per cycle spaces them LANES apart
        for (int i = 1; i <= 8; i++) push(OW'(i), 1);
        drain(0);
        chk("t2_spacing", acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1, LANES);
        compare_words("t2");

        // stall: lanes plus FIFO hold DEPTH+LANES elements, the rest are dropped
        dst_ready = 1'b0;
        for (int i = 0; i < DEPTH + LANES; i++) push(OW'($urandom), 1);
        chk("t3_free0", free, 0);
        chk("t3_no_ovf_yet", overflow, 1'b0);
        chk("t3_valid", dst_valid, 1'b1);
        held = dst_data;
        push(OW'($urandom), 0); push(OW'($urandom), 0);
        chk("t3_ovf", overflow, 1'b1);
        repeat (3) tick();
        chk("t3_stable", dst_data, held);
        chk("t3_stable_mask", dst_mask, 4'hF);
        drain(0);
        chk("t3_nacc", acc_cyc.size(), (DEPTH + LANES) / LANES);
        for (int i = 0; i + 1 < acc_cyc.size(); i++)
            chk($sformatf("t3_spacing%0d", i), acc_cyc[i+1] - acc_cyc[i], LANES);
        compare_words("t3");
        chk("t3_ovf_sticky", overflow, 1'b1);

        // partial word via flush
        push(16'h3F80, 1); push(16'h4000, 1); push(16'h4040, 1);
        do_flush();
        drain(0);
        chk("t4_word", got.size() > 0 ? got[0].data : '0, 64'h0000_4040_4000_3F80);
        compare_words("t4");

        // flush with nothing pending
        flush = 1'b1; tick(); flush = 1'b0; exp_pulses++;
        chk("t5_fdone", flush_done, 1'b1);
        chk("t5_valid", dst_valid, 1'b0);
        tick();
        chk("t5_fdone_low", flush_done, 1'b0);
        drain(0);
        compare_words("t5");

        // reset mid-word discards everything
        push(16'h1111, 0); push(16'h2222, 0);
        rst = 1'b1; tick();
        chk_reset("t6_rst");
        rst = 1'b0;
        push(16'hA001, 1); push(16'hA002, 1); push(16'hA003, 1); push(16'hA004, 1);
        drain(0);
        compare_words("t6");

        // randomized traffic under credit control, random backpressure, then flush
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(5, 40);
            pushed = 0;
            for (int c = 0; c < 2000 && pushed < n; c++) begin
                dst_ready = ($urandom % 4 != 0);
                if (free != '0 && ($urandom % 2 == 0)) begin
                    exp_done = 1'b1; exp_data = OW'($urandom);
                    model_add(exp_data);
                    pushed++;
                end
                tick();
                exp_done = 1'b0;
            end
            chk($sformatf("r%0d_pushed", r), pushed, n);
            do_flush();
            drain(1);
            compare_words($sformatf("r%0d", r));
        end
        chk("rand_no_ovf_path", free, DEPTH);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
